// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the pixel-output path.
package vga_pkg;

  localparam int ADDR_W        = 19;
  localparam int SPRITE_PIXELS = 2500;
  localparam int PIPE_DEPTH    = 3;

  typedef logic [11:0] rgb_t;

  localparam rgb_t COL_BLACK     = 12'h000;
  localparam rgb_t COL_WHITE     = 12'hFFF;
  localparam rgb_t COL_HILITE    = 12'hFF0;
  localparam rgb_t COL_HILITE_BG = 12'h333;
  localparam rgb_t COL_WELCOME   = 12'h0CF;

  typedef struct packed {
    logic square;
    logic hilite;
    logic welcome;
    logic oob;
  } pix_flags_t;

endpackage

// File: rtl/sprite_pixel_pipe_blink_timer.sv
// Frame-based blink generator: toggles blink_on every BLINK_FRAMES vsync falling edges.
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic blink_on
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             vs_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             vs_fall;

  assign vs_fall = vs_q & ~vsync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q      <= 1'b1;
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      vs_q <= vsync;
      if (vs_fall) begin
        if (frame_cnt == LAST) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_pixel_pipe.sv
// Sprite ROM fetch plus sync realignment and final RGB resolve; outputs drive the VGA DAC.
module sprite_pixel_pipe
  import vga_pkg::*;
#(
  parameter int   ROM_DEPTH    = 207500,
  parameter int   BLINK_FRAMES = 30,
  parameter rgb_t BG_COLOR     = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              active,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              square_total,
  input  logic              highlight,
  input  logic              welcome,
  input  logic [ADDR_W-1:0] sprite_address,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs
);

  // One extra bit so depths up to 2^ADDR_W compare correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(ROM_DEPTH);

  logic       unused_xy;
  logic       blink_on;
  pix_flags_t flags_in;
  pix_flags_t flags_p1, flags_p2;
  logic       vld_p1, vld_p2;
  logic       hs_p1, hs_p2;
  logic       vs_p1, vs_p2;
  rgb_t       rgb_p3;

  assign unused_xy = ^{x, y};

  function automatic rgb_t resolve_color(input logic vld, input pix_flags_t f,
                                         input logic [7:0] pix, input logic blink,
                                         input rgb_t bg);
    logic ink;
    ink = f.square & ~f.oob & (pix != 8'h00);
    if (!vld)                            return COL_BLACK;
    if (ink && f.hilite && blink)        return COL_HILITE;
    if (ink && f.welcome)                return COL_WELCOME;
    if (ink)                             return COL_WHITE;
    if (f.square && f.hilite && blink)   return COL_HILITE_BG;
    return bg;
  endfunction

  assign flags_in.square  = square_total;
  assign flags_in.hilite  = highlight;
  assign flags_in.welcome = welcome;
  assign flags_in.oob     = ({1'b0, sprite_address} >= DEPTH_EXT);

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk     (clk),
    .reset   (reset),
    .vsync   (vsync),
    .blink_on(blink_on)
  );

  // Stage 1: issue ROM read, capture flags and syncs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr <= '0;
      flags_p1 <= '0;
      vld_p1   <= 1'b0;
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
    end else begin
      rom_addr <= sprite_address;
      flags_p1 <= flags_in;
      vld_p1   <= active;
      hs_p1    <= hsync;
      vs_p1    <= vsync;
    end
  end

  // Stage 2: wait out the ROM latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_p2 <= '0;
      vld_p2   <= 1'b0;
      hs_p2    <= 1'b1;
      vs_p2    <= 1'b1;
    end else begin
      flags_p2 <= flags_p1;
      vld_p2   <= vld_p1;
      hs_p2    <= hs_p1;
      vs_p2    <= vs_p1;
    end
  end

  // Stage 3: colour resolve against rom_data, registered straight to the pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_p3 <= COL_BLACK;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      rgb_p3 <= resolve_color(vld_p2, flags_p2, rom_data, blink_on, BG_COLOR);
      vga_hs <= hs_p2;
      vga_vs <= vs_p2;
    end
  end

  assign vga_r = rgb_p3[11:8];
  assign vga_g = rgb_p3[7:4];
  assign vga_b = rgb_p3[3:0];

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Directed bench for sprite_pixel_pipe: latency, colour priority, blink timing, reset.
module tb_sprite_pixel_pipe;
  import vga_pkg::*;

  localparam rgb_t BG = 12'h123;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic        active = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        square_total = 1'b0;
  logic        highlight = 1'b0;
  logic        welcome = 1'b0;
  logic [18:0] sprite_address = '0;
  logic [7:0]  rom_val = 8'h00;
  logic [7:0]  rom_q;
  logic [18:0] rom_addr;
  logic [18:0] unused_rom_addr1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, unused_hs1, unused_vs1;
  logic [11:0] rgb, rgb1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous ROM model: data one clock after the address edge.
  always @(posedge clk) rom_q <= rom_val;

  assign rgb  = {r0, g0, b0};
  assign rgb1 = {r1, g1, b1};

  sprite_pixel_pipe #(.ROM_DEPTH(207500), .BLINK_FRAMES(30), .BG_COLOR(BG)) u_dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
    .square_total(square_total), .highlight(highlight), .welcome(welcome),
    .sprite_address(sprite_address), .rom_addr(rom_addr), .rom_data(rom_q),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hs(hs0), .vga_vs(vs0)
  );

  sprite_pixel_pipe #(.ROM_DEPTH(207500), .BLINK_FRAMES(1), .BG_COLOR(BG)) u_dut1 (
    .clk(clk), .reset(reset), .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
    .square_total(square_total), .highlight(highlight), .welcome(welcome),
    .sprite_address(sprite_address), .rom_addr(unused_rom_addr1), .rom_data(rom_q),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(unused_hs1), .vga_vs(unused_vs1)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vs_pulse(input int lo_cycles);
    vsync = 1'b0;
    step(lo_cycles);
    vsync = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    hsync = 1'b0;
    step(2);
    checks++;
    if (hs0 !== 1'b1 || vs0 !== 1'b1) begin
      errors++; $display("FAIL reset_sync hs=%b vs=%b required 1 1", hs0, vs0);
    end
    checks++;
    if (rgb !== 12'h000 || rom_addr !== 19'd0) begin
      errors++; $display("FAIL reset_out rgb=%h rom_addr=%0d required 000 0", rgb, rom_addr);
    end
    reset = 1'b1;
    step(2);
    checks++;
    if (hs0 !== 1'b1 || rgb !== 12'h000) begin
      errors++; $display("FAIL reset_hs_hold hs=%b rgb=%h required 1 000", hs0, rgb);
    end
    step(1);
    checks++;
    if (hs0 !== 1'b0 || rgb !== 12'h000) begin
      errors++; $display("FAIL reset_hs_lag3 hs=%b rgb=%h required 0 000", hs0, rgb);
    end
    hsync = 1'b1;
    step(3);
  endtask

  task automatic test_ink;
    active = 1'b1; square_total = 1'b1; sprite_address = 19'd1234; rom_val = 8'h01;
    hsync = 1'b0;
    step(1);
    checks++;
    if (rom_addr !== 19'd1234) begin
      errors++; $display("FAIL ink_rom_addr got=%0d required 1234", rom_addr);
    end
    step(1);
    checks++;
    if (rgb !== 12'h000 || hs0 !== 1'b1) begin
      errors++; $display("FAIL ink_early rgb=%h hs=%b required 000 1", rgb, hs0);
    end
    step(1);
    checks++;
    if (rgb !== 12'hFFF || hs0 !== 1'b0) begin
      errors++; $display("FAIL ink_lat3 rgb=%h hs=%b required fff 0", rgb, hs0);
    end
    hsync = 1'b1;
    step(3);
  endtask

  task automatic test_highlight_blink;
    highlight = 1'b1;
    step(3);
    checks++;
    if (rgb !== 12'hFF0) begin
      errors++; $display("FAIL hl_on got=%h required ff0", rgb);
    end
    vs_pulse(1);
    checks++;
    if (rgb1 !== 12'hFFF) begin
      errors++; $display("FAIL bf1_edge1 got=%h required fff", rgb1);
    end
    vs_pulse(6);
    checks++;
    if (rgb1 !== 12'hFF0) begin
      errors++; $display("FAIL bf1_edge2 got=%h required ff0", rgb1);
    end
    for (int i = 2; i < 29; i++) vs_pulse(1);
    checks++;
    if (rgb !== 12'hFF0) begin
      errors++; $display("FAIL hl_edge29 got=%h required ff0", rgb);
    end
    vs_pulse(1);
    checks++;
    if (rgb !== 12'hFFF) begin
      errors++; $display("FAIL hl_edge30 got=%h required fff", rgb);
    end
    rom_val = 8'h00;
    step(3);
    checks++;
    if (rgb !== BG) begin
      errors++; $display("FAIL hl_off_transp got=%h required %h", rgb, BG);
    end
    rom_val = 8'h01;
    for (int i = 0; i < 30; i++) vs_pulse(1);
    step(3);
    checks++;
    if (rgb !== 12'hFF0) begin
      errors++; $display("FAIL hl_edge60 got=%h required ff0", rgb);
    end
  endtask

  task automatic test_colours;
    rom_val = 8'h00; highlight = 1'b1; welcome = 1'b0;
    step(3);
    checks++;
    if (rgb !== 12'h333) begin
      errors++; $display("FAIL hl_transp got=%h required 333", rgb);
    end
    rom_val = 8'h01; highlight = 1'b0; welcome = 1'b1;
    step(3);
    checks++;
    if (rgb !== 12'h0CF) begin
      errors++; $display("FAIL welcome_ink got=%h required 0cf", rgb);
    end
    highlight = 1'b1;
    step(3);
    checks++;
    if (rgb !== 12'hFF0) begin
      errors++; $display("FAIL hl_beats_welcome got=%h required ff0", rgb);
    end
    highlight = 1'b0; welcome = 1'b0; square_total = 1'b0;
    step(3);
    checks++;
    if (rgb !== BG) begin
      errors++; $display("FAIL no_square got=%h required %h", rgb, BG);
    end
    square_total = 1'b1;
  endtask

  task automatic test_oob;
    rom_val = 8'hFF; sprite_address = 19'h7FFFF;
    step(3);
    checks++;
    if (rgb !== BG) begin
      errors++; $display("FAIL oob_max got=%h required %h", rgb, BG);
    end
    sprite_address = 19'd207500;
    step(3);
    checks++;
    if (rgb !== BG) begin
      errors++; $display("FAIL oob_depth got=%h required %h", rgb, BG);
    end
    sprite_address = 19'd207499;
    step(3);
    checks++;
    if (rgb !== 12'hFFF) begin
      errors++; $display("FAIL last_word got=%h required fff", rgb);
    end
    active = 1'b0;
    step(3);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL inactive got=%h required 000", rgb);
    end
    active = 1'b1; rom_val = 8'h01; sprite_address = 19'd1234;
  endtask

  task automatic test_reset_midframe;
    highlight = 1'b1; hsync = 1'b0;
    step(3);
    for (int i = 0; i < 10; i++) vs_pulse(1);
    checks++;
    if (rgb !== 12'hFF0 || hs0 !== 1'b0) begin
      errors++; $display("FAIL pre_reset rgb=%h hs=%b required ff0 0", rgb, hs0);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (rgb !== 12'h000 || hs0 !== 1'b1 || rom_addr !== 19'd0) begin
      errors++; $display("FAIL async_clear rgb=%h hs=%b rom_addr=%0d required 000 1 0", rgb, hs0, rom_addr);
    end
    step(1);
    reset = 1'b1;
    step(2);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL post_reset_early got=%h required 000", rgb);
    end
    step(1);
    checks++;
    if (rgb !== 12'hFF0) begin
      errors++; $display("FAIL post_reset_first got=%h required ff0", rgb);
    end
    for (int i = 0; i < 29; i++) vs_pulse(1);
    checks++;
    if (rgb !== 12'hFF0) begin
      errors++; $display("FAIL post_reset_edge29 got=%h required ff0", rgb);
    end
    vs_pulse(1);
    checks++;
    if (rgb !== 12'hFFF) begin
      errors++; $display("FAIL post_reset_edge30 got=%h required fff", rgb);
    end
  endtask

  initial begin
    test_reset;
    test_ink;
    test_highlight_blink;
    test_colours;
    test_oob;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
